// File: rtl/ifetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_stage
// Description : Instruction fetch stage for the MIPS-subset core. Holds the
//               program counter, presents it to a combinational instruction
//               ROM, and captures the returned word into the IF/ID pipeline
//               register. Handles hazard stalls, branch/jump redirects with
//               flush, HALT detection and a saturating fetch counter.
//
// Ports       : clk          - system clock, rising-edge active
//               reset_n      - asynchronous active-low reset
//               imem_addr    - ROM fetch address (copy of the PC register)
//               imem_data    - ROM instruction word for imem_addr
//               stall        - hold PC, IF/ID, state and fetch counter
//               redirect     - load redirect_pc and flush IF/ID
//               redirect_pc  - redirect target address
//               ifid_instr   - registered instruction to decode
//               ifid_pc4     - registered PC+4 of ifid_instr
//               ifid_valid   - ifid_instr is a real fetch, not a bubble
//               halted       - high while in the HALT state
//               misalign     - sticky: a redirect target had bits [1:0] != 0
//               fetch_count  - saturating count of valid captures
//
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'd63,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted,
    output logic        misalign,
    output logic [15:0] fetch_count
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [15:0] c_COUNT_MAX = 16'hFFFF;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic        r_misalign;
    logic [15:0] r_count;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc4_nxt;
    logic        w_valid_nxt;
    logic        w_misalign_nxt;
    logic [15:0] w_count_nxt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_target;
    logic        w_is_halt;
    logic        w_target_misaligned;

    // PC arithmetic wraps modulo 2^32 by virtue of the 32-bit result width.
    assign w_pc_plus4          = r_pc + 32'd4;
    // Targets are forced word-aligned; the low bits only feed the sticky flag.
    assign w_redirect_target   = {redirect_pc[31:2], 2'b00};
    assign w_target_misaligned = |redirect_pc[1:0];
    assign w_is_halt           = (imem_data[31:26] == HALT_OPCODE);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_pc4_nxt      = r_pc4;
        w_valid_nxt    = r_valid;
        w_misalign_nxt = r_misalign;
        w_count_nxt    = r_count;

        if (redirect) begin
            // Redirect wins over stall. From HALT it means the HALT word
            // was fetched down a wrong path, so resume running.
            w_pc_nxt       = w_redirect_target;
            w_instr_nxt    = NOP_WORD;
            w_valid_nxt    = 1'b0;
            w_misalign_nxt = r_misalign | w_target_misaligned;
            w_state_nxt    = ST_RUN;
        end else if (stall) begin
            // Everything holds (defaults).
        end else begin
            case (r_state)
                ST_RUN: begin
                    w_instr_nxt = imem_data;
                    w_pc4_nxt   = w_pc_plus4;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = w_pc_plus4;
                    if (r_count != c_COUNT_MAX) begin
                        w_count_nxt = r_count + 16'd1;
                    end
                    // The HALT word itself is delivered; the stage stops
                    // fetching from the following edge.
                    if (w_is_halt) begin
                        w_state_nxt = ST_HALT;
                    end
                end
                ST_HALT: begin
                    // PC stays at the address after the HALT word.
                    w_instr_nxt = NOP_WORD;
                    w_valid_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_instr    <= NOP_WORD;
            r_pc4      <= 32'h0000_0000;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
            r_count    <= 16'h0000;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_pc4      <= w_pc4_nxt;
            r_valid    <= w_valid_nxt;
            r_misalign <= w_misalign_nxt;
            r_count    <= w_count_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_addr   = r_pc;
    assign ifid_instr  = r_instr;
    assign ifid_pc4    = r_pc4;
    assign ifid_valid  = r_valid;
    assign halted      = (r_state == ST_HALT);
    assign misalign    = r_misalign;
    assign fetch_count = r_count;

endmodule
`default_nettype wire
